// File: rtl/clock_enable_controller.sv
// Processor clock sequencer: divides the board clock into a one-cycle cpu_ce pulse
// with run / halt / single-step control and a reconfigurable divide ratio.
module clock_enable_controller #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic             halt,
  input  logic             step,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             cpu_ce,
  output logic             tick_div2,
  output logic [1:0]       state,
  output logic             cfg_ack,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  state_t           st;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last_cnt;

  // Terminal count D-1, with a stored ratio of 0 clamped to behave as D=1.
  function automatic logic [DIV_W-1:0] terminal_count(input logic [DIV_W-1:0] div);
    if (div == '0)
      return '0;
    else
      return div - DIV_W'(1);
  endfunction

  assign last_cnt = terminal_count(div_reg);
  assign state    = st;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      st        <= ST_HALT;
      cnt       <= '0;
      div_reg   <= DIV_W'(DEFAULT_DIV);
      cpu_ce    <= 1'b0;
      tick_div2 <= 1'b0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cpu_ce  <= 1'b0;
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;

      // The ratio only changes in HALT, so a run/step starting this edge sees the new value.
      if (div_load) begin
        if (st == ST_HALT) begin
          div_reg <= div_value;
          cfg_ack <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      case (st)
        ST_HALT: begin
          cnt <= '0;
          if (!halt) begin
            if (step)
              st <= ST_STEP;
            else if (run)
              st <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (halt || !run) begin
            st  <= ST_HALT;
            cnt <= '0;
          end else if (cnt == last_cnt) begin
            cnt       <= '0;
            cpu_ce    <= 1'b1;
            tick_div2 <= ~tick_div2;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        ST_STEP: begin
          if (halt) begin
            st  <= ST_HALT;
            cnt <= '0;
          end else if (cnt == last_cnt) begin
            st        <= ST_HALT;
            cnt       <= '0;
            cpu_ce    <= 1'b1;
            tick_div2 <= ~tick_div2;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: begin
          st  <= ST_HALT;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
